// File: rtl/mem_log_dumper_pkg.sv
// Shared definitions for the log dumper: default RAM geometry (matching the
// capture logger), dump FSM state encoding and the bytes-per-word helper.
package mem_log_dumper_pkg;

    localparam int DEF_RAM_WIDTH      = 32;
    localparam int DEF_RAM_ADDR_NBIT  = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

    function automatic int bytes_per_word(input int ram_width);
        return ram_width / 8;
    endfunction

    localparam int DEF_BYTES_PER_WORD = bytes_per_word(DEF_RAM_WIDTH);

endpackage

// File: rtl/mem_log_dumper_word_serializer.sv
// Splits one RAM word into bytes, MSB byte first, on a valid/ready stream.
// valid/ready: a byte transfers on any cycle where valid_o && ready_i; byte_o is held while valid_o && !ready_i.
module mem_log_dumper_word_serializer
    import mem_log_dumper_pkg::*;
#(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [RAM_WIDTH-1:0] word_i,
    output logic [7:0]           byte_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o
);

    localparam int BPW   = bytes_per_word(RAM_WIDTH);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [RAM_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 valid_q;
    logic                 accept;

    assign accept  = valid_q && ready_i;
    assign last_o  = accept && (idx_q == LAST_IDX);
    assign byte_o  = shift_q[RAM_WIDTH-1 -: 8];
    assign valid_o = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= word_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else begin
            if (accept) begin
                shift_q <= shift_q << 8;
                idx_q   <= idx_q + IDX_W'(1);
            end
            if (last_o || clear_i) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_log_dumper.sv
// Sweeps the whole log RAM after a completed capture and streams every word
// out as bytes toward the UART; a fresh capture (mem_full low) aborts the sweep.
module mem_log_dumper
    import mem_log_dumper_pkg::*;
#(
    parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int RAM_ADDR_NBIT = DEF_RAM_ADDR_NBIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_mem_full,
    output logic                     o_read,
    output logic [RAM_ADDR_NBIT-1:0] o_address,
    input  logic [RAM_WIDTH-1:0]     i_data,
    output logic [7:0]               o_byte,
    output logic                     o_byte_valid,
    input  logic                     i_byte_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_abort
);

    // One spare bit so the last-address compare never sees a wrapped counter.
    localparam int AW = RAM_ADDR_NBIT + 1;
    localparam logic [AW-1:0] LAST_ADDR = {1'b0, {RAM_ADDR_NBIT{1'b1}}};

    dump_state_e    state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           start_q;
    logic           abort_pend_q, abort_pend_d;
    logic           done_q;
    logic           abort_q, abort_d;
    logic           start_edge;
    logic           load, clear;
    logic           ser_valid, ser_last, accept;

    assign start_edge = i_start && !start_q;
    assign accept     = ser_valid && i_byte_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            start_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            start_q      <= i_start;
            abort_pend_q <= abort_pend_d;
            done_q       <= (state_q == ST_DONE);
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        abort_pend_d = 1'b0;
        abort_d      = 1'b0;
        load         = 1'b0;
        clear        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge && i_mem_full) begin
                    state_d = ST_REQ;
                    addr_d  = '0;
                end
            end
            ST_REQ: begin
                if (!i_mem_full) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_mem_full) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // A drop of mem_full is remembered so the held byte still completes.
                abort_pend_d = abort_pend_q || !i_mem_full;
                if (accept) begin
                    if (abort_pend_d) begin
                        state_d      = ST_IDLE;
                        abort_d      = 1'b1;
                        clear        = 1'b1;
                        abort_pend_d = 1'b0;
                    end else if (ser_last) begin
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + AW'(1);
                            state_d = ST_REQ;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_read       = (state_q == ST_REQ);
    assign o_address    = addr_q[RAM_ADDR_NBIT-1:0];
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;
    assign o_abort      = abort_q;
    assign o_byte_valid = ser_valid;

    mem_log_dumper_word_serializer #(
        .RAM_WIDTH (RAM_WIDTH)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .clear_i (clear),
        .word_i  (i_data),
        .byte_o  (o_byte),
        .valid_o (ser_valid),
        .ready_i (i_byte_ready),
        .last_o  (ser_last)
    );

endmodule

// File: tb/tb_mem_log_dumper.sv
// Bench for mem_log_dumper on an 8-word RAM: full dumps under several ready
// patterns, ignored starts, abort mid-handshake and reset mid-dump.
module tb_mem_log_dumper;

    localparam int W     = 32;
    localparam int AN    = 3;
    localparam int DEPTH = 1 << AN;
    localparam int BPW   = W / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          i_mem_full;
    logic          o_read;
    logic [AN-1:0] o_address;
    logic [W-1:0]  i_data = '0;
    logic [7:0]    o_byte;
    logic          o_byte_valid;
    logic          i_byte_ready = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic          o_abort;

    logic [W-1:0]  mem [DEPTH];
    logic [7:0]    exp_q [$];
    logic [AN-1:0] exp_addr_q [$];
    int            rd_cyc [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int done_cyc = 0;
    int rdy_mode = 0;
    logic man_ready = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_byte = '0;

    mem_log_dumper #(.RAM_WIDTH(W), .RAM_ADDR_NBIT(AN)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_mem_full   (i_mem_full),
        .o_read       (o_read),
        .o_address    (o_address),
        .i_data       (i_data),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_abort      (o_abort)
    );

    // ---------------- clock / reset / environment ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data appears the cycle after the read strobe.
    always @(posedge clk) if (o_read) i_data <= mem[o_address];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: i_byte_ready = 1'b1;
                1: i_byte_ready = (cyc % 3 == 0);
                2: i_byte_ready = 1'($urandom_range(0, 1));
                default: i_byte_ready = man_ready;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void push_word(input logic [W-1:0] w, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            exp_q.push_back(8'((w >> (8 * (BPW - 1 - b))) & 32'hFF));
        end
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (o_read) begin
                rd_cyc.push_back(cyc);
                if (exp_addr_q.size() == 0) check("rd_extra", 1, 0);
                else check("rd_addr", 32'(o_address), 32'(exp_addr_q.pop_front()));
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(o_byte_valid), 1);
                check("hold_byte", 32'(o_byte), 32'(prev_byte));
            end
            if (o_byte_valid) check("valid_busy", 32'(o_busy), 1);
            if (o_byte_valid && i_byte_ready) begin
                if (exp_q.size() == 0) check("byte_extra", 1, 0);
                else check("byte", 32'(o_byte), 32'(exp_q.pop_front()));
            end
            if (o_done || o_abort) check("done_abort_excl", 32'(o_done & o_abort), 0);
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_abort) abort_cnt++;
            prev_valid = o_byte_valid;
            prev_ready = i_byte_ready;
            prev_byte  = o_byte;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_outputs_zero(input string tag);
        check({tag, "_read"},  32'(o_read), 0);
        check({tag, "_addr"},  32'(o_address), 0);
        check({tag, "_byte"},  32'(o_byte), 0);
        check({tag, "_valid"}, 32'(o_byte_valid), 0);
        check({tag, "_busy"},  32'(o_busy), 0);
        check({tag, "_done"},  32'(o_done), 0);
        check({tag, "_abort"}, 32'(o_abort), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        repeat (2) @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc);
        int d0 = done_cnt;
        int a0 = abort_cnt;
        int t = 0;
        while (done_cnt == d0 && abort_cnt == a0 && t < max_cyc) begin
            @(posedge clk);
            t++;
        end
        check("end_timeout", 32'(t < max_cyc), 1);
    endtask

    task automatic accept_one();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_byte_valid && t < 50);
        check("accept_timeout", 32'(t < 50), 1);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
    endtask

    task automatic fill_mem(input bit fixed_pat);
        exp_q.delete();
        exp_addr_q.delete();
        rd_cyc.delete();
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = fixed_pat ? (32'hA0B0C000 + 32'(k)) : $urandom;
        end
    endtask

    task automatic run_dump(input int mode, input bit fixed_pat, input bit check_lat, input int restart_at);
        int d0, a0;
        fill_mem(fixed_pat);
        for (int k = 0; k < DEPTH; k++) begin
            push_word(mem[k], BPW);
            exp_addr_q.push_back(AN'(k));
        end
        rdy_mode = mode;
        d0 = done_cnt;
        a0 = abort_cnt;
        pulse_start();
        if (restart_at > 0) begin
            repeat (restart_at) @(negedge clk);
            pulse_start();
        end
        wait_end(600);
        repeat (10) @(negedge clk);
        check("dump_done_cnt", 32'(done_cnt - d0), 1);
        check("dump_abort_cnt", 32'(abort_cnt - a0), 0);
        check("dump_bytes_left", 32'(exp_q.size()), 0);
        check("dump_reads_left", 32'(exp_addr_q.size()), 0);
        check("dump_busy_after", 32'(o_busy), 0);
        if (check_lat) begin
            check("rd_count", 32'(rd_cyc.size()), DEPTH);
            for (int i = 1; i < rd_cyc.size(); i++) begin
                check("rd_space", 32'(rd_cyc[i] - rd_cyc[i-1]), 2 + BPW);
            end
            if (rd_cyc.size() > 0) check("done_lat", 32'(done_cyc - rd_cyc[0]), DEPTH * (2 + BPW) + 1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0, a0, t;
        rst = 1'b0;
        i_start = 1'b0;
        i_mem_full = 1'b1;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Full dump, ready high: order, spacing and latency.
        run_dump(0, 1'b1, 1'b1, 0);
        // Full dump, ready 1-of-3.
        run_dump(1, 1'b1, 1'b0, 0);
        // Full dump, random data and random ready.
        run_dump(2, 1'b0, 1'b0, 0);

        // Start edge without a finished capture is ignored.
        fill_mem(1'b0);
        d0 = done_cnt;
        i_mem_full = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("nofull_idle", {29'd0, o_read, o_busy, o_byte_valid}, 0);
        end
        check("nofull_done", 32'(done_cnt - d0), 0);
        i_mem_full = 1'b1;

        // Abort while word 2 byte 1 is held with ready low.
        fill_mem(1'b0);
        push_word(mem[0], BPW);
        push_word(mem[1], BPW);
        push_word(mem[2], 2);
        for (int k = 0; k < 3; k++) exp_addr_q.push_back(AN'(k));
        man_ready = 1'b0;
        rdy_mode = 3;
        d0 = done_cnt;
        a0 = abort_cnt;
        pulse_start();
        for (int i = 0; i < 2 * BPW + 1; i++) accept_one();
        repeat (2) @(negedge clk);
        i_mem_full = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_held_valid", 32'(o_byte_valid), 1);
        check("abort_no_pulse_yet", 32'(abort_cnt - a0), 0);
        accept_one();
        wait_end(20);
        repeat (20) @(negedge clk);
        check("abort_cnt", 32'(abort_cnt - a0), 1);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check("abort_bytes_left", 32'(exp_q.size()), 0);
        check("abort_reads_left", 32'(exp_addr_q.size()), 0);
        check("abort_busy", 32'(o_busy), 0);
        i_mem_full = 1'b1;

        // Second start edge mid-dump is ignored.
        run_dump(2, 1'b0, 1'b0, 15);

        // Reset during SEND of word 4.
        fill_mem(1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            push_word(mem[k], BPW);
            exp_addr_q.push_back(AN'(k));
        end
        rdy_mode = 0;
        pulse_start();
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!(o_read && o_address == AN'(4)) && t < 200);
        check("rst_reach_word4", 32'(t < 200), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        check("rst_in_send", 32'(o_byte_valid), 1);
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_idle", {30'd0, o_busy, o_done}, 0);
        end
        run_dump(2, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
